// File: rtl/wts_key_event_generator.sv
// wts_key_event_generator
// Register-file front end and key-event sequencer for one wave-table channel.
// CPU writes set the envelope rates, sustain level and gate length. KEY
// writes queue one command that is emitted as a single-cycle pulse on the
// next `active` tick. A gate timer can issue an automatic key_release.
module wts_key_event_generator (
    input  logic       clk,
    input  logic       nreset,
    input  logic       active,
    input  logic       bus_write,
    input  logic [2:0] bus_address,
    input  logic [7:0] bus_wdata,
    output logic       key_on,
    output logic       key_release,
    output logic       key_off,
    output logic [7:0] reg_ar,
    output logic [7:0] reg_dr,
    output logic [7:0] reg_sr,
    output logic [7:0] reg_rr,
    output logic [6:0] reg_sl,
    output logic       gate_active,
    output logic       cmd_pending
);

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_ON   = 2'd1,
        CMD_REL  = 2'd2,
        CMD_OFF  = 2'd3
    } cmd_e;

    typedef struct packed {
        logic [7:0]  ar;
        logic [7:0]  dr;
        logic [7:0]  sr;
        logic [7:0]  rr;
        logic [6:0]  sl;
        logic [15:0] gate_len;
    } env_regs_t;

    env_regs_t   regs_q;
    cmd_e        pend_q, pend_d;
    cmd_e        key_cmd;
    logic        key_wr;
    logic [15:0] gate_cnt_q, gate_cnt_d;
    logic        gate_q, gate_d;
    logic        timer_fire;

    // Register file: captured on any write strobe, independent of `active`.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            regs_q <= '0;
        end else if (bus_write) begin
            case (bus_address)
                3'd0: regs_q.ar             <= bus_wdata;
                3'd1: regs_q.dr             <= bus_wdata;
                3'd2: regs_q.sr             <= bus_wdata;
                3'd3: regs_q.rr             <= bus_wdata;
                3'd4: regs_q.sl             <= bus_wdata[6:0];
                3'd5: regs_q.gate_len[7:0]  <= bus_wdata;
                3'd6: regs_q.gate_len[15:8] <= bus_wdata;
                default: ;
            endcase
        end
    end

    // KEY decode: OFF beats ON beats RELEASE; all-zero command bits mean no command.
    always_comb begin
        key_wr  = bus_write && (bus_address == 3'd7);
        key_cmd = CMD_NONE;
        if (bus_wdata[2])      key_cmd = CMD_OFF;
        else if (bus_wdata[0]) key_cmd = CMD_ON;
        else if (bus_wdata[1]) key_cmd = CMD_REL;
    end

    // Pending command state register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) pend_q <= CMD_NONE;
        else         pend_q <= pend_d;
    end

    // Pending next state: an active tick emits and clears; a fresh KEY write
    // lands afterwards, so it overrides both the old command and the clear.
    always_comb begin
        pend_d = pend_q;
        if (active)
            pend_d = CMD_NONE;
        if (key_wr && (key_cmd != CMD_NONE))
            pend_d = key_cmd;
    end

    // Timer expiry only counts when no command is competing for the tick.
    assign timer_fire = active && (pend_q == CMD_NONE) && (gate_cnt_q == 16'd1);

    // Gate timer and gate flag next state, advanced only on active ticks.
    always_comb begin
        gate_cnt_d = gate_cnt_q;
        gate_d     = gate_q;
        if (active) begin
            case (pend_q)
                CMD_ON: begin
                    gate_cnt_d = regs_q.gate_len;
                    gate_d     = 1'b1;
                end
                CMD_REL, CMD_OFF: begin
                    gate_cnt_d = '0;
                    gate_d     = 1'b0;
                end
                default: begin
                    if (gate_cnt_q == 16'd1) begin
                        gate_cnt_d = '0;
                        gate_d     = 1'b0;
                    end else if (gate_cnt_q > 16'd1) begin
                        gate_cnt_d = gate_cnt_q - 16'd1;
                    end
                end
            endcase
        end
    end

    // Gate timer and gate flag registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            gate_cnt_q <= '0;
            gate_q     <= 1'b0;
        end else begin
            gate_cnt_q <= gate_cnt_d;
            gate_q     <= gate_d;
        end
    end

    // Pulses are combinational with `active`, so their width is one tick.
    assign key_on      = active && (pend_q == CMD_ON);
    assign key_off     = active && (pend_q == CMD_OFF);
    assign key_release = (active && (pend_q == CMD_REL)) || timer_fire;

    assign reg_ar      = regs_q.ar;
    assign reg_dr      = regs_q.dr;
    assign reg_sr      = regs_q.sr;
    assign reg_rr      = regs_q.rr;
    assign reg_sl      = regs_q.sl;
    assign gate_active = gate_q;
    assign cmd_pending = (pend_q != CMD_NONE);

endmodule

// File: tb/tb_wts_key_event_generator.sv
// Testbench for wts_key_event_generator: directed scenarios plus random
// traffic, each cycle compared with a command-queue / tick-countdown model.
module tb_wts_key_event_generator;

    logic       clk = 1'b0;
    logic       nreset = 1'b1;
    logic       active = 1'b0;
    logic       bus_write = 1'b0;
    logic [2:0] bus_address = '0;
    logic [7:0] bus_wdata = '0;
    logic       key_on, key_release, key_off, gate_active, cmd_pending;
    logic [7:0] reg_ar, reg_dr, reg_sr, reg_rr;
    logic [6:0] reg_sl;

    wts_key_event_generator dut (
        .clk(clk), .nreset(nreset), .active(active), .bus_write(bus_write),
        .bus_address(bus_address), .bus_wdata(bus_wdata),
        .key_on(key_on), .key_release(key_release), .key_off(key_off),
        .reg_ar(reg_ar), .reg_dr(reg_dr), .reg_sr(reg_sr), .reg_rr(reg_rr),
        .reg_sl(reg_sl), .gate_active(gate_active), .cmd_pending(cmd_pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model: last-written command name, ticks left before auto-release.
    string      m_cmd;
    int         m_left;
    bit         m_gate;
    logic [7:0] m_ar, m_dr, m_sr, m_rr;
    logic [6:0] m_sl;
    int         m_g;
    logic [43:0] e_out;

    function automatic logic [43:0] dvec();
        return {key_on, key_release, key_off, gate_active, cmd_pending,
                reg_ar, reg_dr, reg_sr, reg_rr, reg_sl};
    endfunction

    function automatic void m_reset();
        m_cmd = "";
        m_left = 0; m_gate = 0; m_g = 0;
        m_ar = 0; m_dr = 0; m_sr = 0; m_rr = 0; m_sl = 0;
    endfunction

    // Drive one cycle, leave the expected pre-edge outputs in e_out, advance model.
    task automatic step(input bit act, input bit wr, input logic [2:0] a, input logic [7:0] d);
        logic [2:0] pul;
        @(negedge clk);
        active = act; bus_write = wr; bus_address = a; bus_wdata = d;
        #1;
        pul = 3'b000;
        if (act) begin
            if (m_cmd == "OFF")      pul = 3'b001;
            else if (m_cmd == "ON")  pul = 3'b100;
            else if (m_cmd == "REL") pul = 3'b010;
            else if (m_left == 1)    pul = 3'b010;
        end
        e_out = {pul, m_gate, (m_cmd != ""), m_ar, m_dr, m_sr, m_rr, m_sl};
        if (act) begin
            if (m_cmd == "ON") begin
                m_gate = 1; m_left = m_g;
            end else if (m_cmd != "" || m_left == 1) begin
                m_gate = 0; m_left = 0;
            end else if (m_left > 1) begin
                m_left = m_left - 1;
            end
            m_cmd = "";
        end
        if (wr) begin
            case (a)
                3'd0: m_ar = d;
                3'd1: m_dr = d;
                3'd2: m_sr = d;
                3'd3: m_rr = d;
                3'd4: m_sl = d[6:0];
                3'd5: m_g = (m_g & 32'hFF00) | int'(d);
                3'd6: m_g = (m_g & 32'h00FF) | (int'(d) << 8);
                default: begin
                    if (d[2])      m_cmd = "OFF";
                    else if (d[0]) m_cmd = "ON";
                    else if (d[1]) m_cmd = "REL";
                end
            endcase
        end
    endtask

    task automatic test_reset();
        #2 nreset = 1'b0;
        #1;
        checks++; if (dvec() !== 44'h0) $display("FAIL reset_init got=%h exp=0", dvec()); else passed++;
        @(negedge clk); @(negedge clk); nreset = 1'b1;
        m_reset();
        step(0, 1, 3'd0, 8'h5A);
        step(0, 1, 3'd7, 8'h01);
        step(0, 0, 3'd0, 8'h00);
        checks++; if (cmd_pending !== 1'b1 || reg_ar !== 8'h5A) $display("FAIL reset_pre pend=%b ar=%h exp pend=1 ar=5a", cmd_pending, reg_ar); else passed++;
        #2 nreset = 1'b0; active = 1'b1;
        #1;
        checks++; if (dvec() !== 44'h0) $display("FAIL reset_mid got=%h exp=0", dvec()); else passed++;
        m_reset();
        @(negedge clk); nreset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 3'd0, 8'h00);
            checks++; if (dvec() !== e_out || key_on !== 1'b0) $display("FAIL reset_after cyc=%0d got=%h exp=%h", i, dvec(), e_out); else passed++;
        end
    endtask

    task automatic test_regs();
        step(0, 1, 3'd0, 8'h12);
        step(0, 1, 3'd4, 8'hFF);
        checks++; if (reg_ar !== 8'h12) $display("FAIL reg_ar got=%h exp=12", reg_ar); else passed++;
        step(0, 1, 3'd1, 8'h34);
        checks++; if (reg_sl !== 7'h7F) $display("FAIL reg_sl got=%h exp=7f", reg_sl); else passed++;
        step(0, 1, 3'd2, 8'h56);
        step(0, 1, 3'd3, 8'h78);
        step(0, 0, 3'd0, 8'h00);
        checks++; if (dvec() !== e_out || {reg_dr, reg_sr, reg_rr} !== 24'h345678) $display("FAIL reg_all got=%h exp=%h", dvec(), e_out); else passed++;
    endtask

    task automatic test_key_on();
        step(0, 1, 3'd7, 8'h01);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 3'd0, 8'h00);
            checks++; if (cmd_pending !== 1'b1 || key_on !== 1'b0 || dvec() !== e_out) $display("FAIL keyon_wait cyc=%0d got=%h exp=%h", i, dvec(), e_out); else passed++;
        end
        step(1, 0, 3'd0, 8'h00);
        checks++; if ({key_on, key_release, key_off} !== 3'b100 || dvec() !== e_out) $display("FAIL keyon_pulse got=%h exp=%h", dvec(), e_out); else passed++;
        step(0, 0, 3'd0, 8'h00);
        checks++; if (key_on !== 1'b0 || gate_active !== 1'b1 || cmd_pending !== 1'b0) $display("FAIL keyon_after on=%b gate=%b pend=%b exp 0 1 0", key_on, gate_active, cmd_pending); else passed++;
    endtask

    task automatic test_auto_release();
        int n_act, rel_at, rel_cnt;
        step(0, 1, 3'd5, 8'h03);
        step(0, 1, 3'd6, 8'h00);
        step(0, 1, 3'd7, 8'h01);
        step(1, 0, 3'd0, 8'h00);
        checks++; if (key_on !== 1'b1) $display("FAIL auto_keyon got=%b exp=1", key_on); else passed++;
        n_act = 0; rel_at = 0;
        for (int i = 0; i < 15; i++) begin
            step(i % 3 == 2, 0, 3'd0, 8'h00);
            if (active) n_act++;
            if (key_release === 1'b1 && rel_at == 0) rel_at = n_act;
            checks++; if (dvec() !== e_out) $display("FAIL auto_cyc cyc=%0d got=%h exp=%h", i, dvec(), e_out); else passed++;
        end
        checks++; if (rel_at != 3 || gate_active !== 1'b0) $display("FAIL auto_g3 rel_at=%0d gate=%b exp 3 0", rel_at, gate_active); else passed++;
        step(0, 1, 3'd5, 8'h00);
        step(0, 1, 3'd7, 8'h01);
        step(1, 0, 3'd0, 8'h00);
        rel_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            step(i % 2 == 1, 0, 3'd0, 8'h00);
            if (key_release === 1'b1) rel_cnt++;
        end
        checks++; if (rel_cnt != 0 || gate_active !== 1'b1) $display("FAIL auto_g0 releases=%0d gate=%b exp 0 1", rel_cnt, gate_active); else passed++;
    endtask

    task automatic test_priority();
        step(0, 1, 3'd7, 8'h07);
        step(1, 0, 3'd0, 8'h00);
        checks++; if ({key_on, key_release, key_off} !== 3'b001 || dvec() !== e_out) $display("FAIL prio_off got=%h exp=%h", dvec(), e_out); else passed++;
        step(0, 1, 3'd7, 8'h01);
        step(0, 1, 3'd7, 8'h02);
        step(0, 1, 3'd7, 8'h08);
        step(1, 0, 3'd0, 8'h00);
        checks++; if ({key_on, key_release, key_off} !== 3'b010 || dvec() !== e_out) $display("FAIL prio_lastwins got=%h exp=%h", dvec(), e_out); else passed++;
        step(1, 0, 3'd0, 8'h00);
        checks++; if ({key_on, key_release, key_off} !== 3'b000) $display("FAIL prio_single got=%b exp=000", {key_on, key_release, key_off}); else passed++;
    endtask

    task automatic test_collision();
        step(0, 1, 3'd5, 8'h02);
        step(0, 1, 3'd7, 8'h01);
        step(1, 0, 3'd0, 8'h00);
        step(0, 0, 3'd0, 8'h00);
        step(1, 0, 3'd0, 8'h00);
        checks++; if (key_release !== 1'b0 || gate_active !== 1'b1) $display("FAIL coll_first rel=%b gate=%b exp 0 1", key_release, gate_active); else passed++;
        step(0, 1, 3'd7, 8'h04);
        step(1, 0, 3'd0, 8'h00);
        checks++; if ({key_on, key_release, key_off} !== 3'b001 || dvec() !== e_out) $display("FAIL coll_off got=%h exp=%h", dvec(), e_out); else passed++;
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 3'd0, 8'h00);
            checks++; if (key_release !== 1'b0 || dvec() !== e_out) $display("FAIL coll_after cyc=%0d got=%h exp=%h", i, dvec(), e_out); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        step(0, 1, 3'd5, 8'h00);
        step(0, 1, 3'd7, 8'h01);
        step(1, 1, 3'd7, 8'h02);
        checks++; if (key_on !== 1'b1) $display("FAIL b2b_on got=%b exp=1", key_on); else passed++;
        step(0, 0, 3'd0, 8'h00);
        checks++; if (cmd_pending !== 1'b1 || gate_active !== 1'b1) $display("FAIL b2b_pend pend=%b gate=%b exp 1 1", cmd_pending, gate_active); else passed++;
        step(1, 0, 3'd0, 8'h00);
        checks++; if ({key_on, key_release, key_off} !== 3'b010 || dvec() !== e_out) $display("FAIL b2b_rel got=%h exp=%h", dvec(), e_out); else passed++;
        step(0, 1, 3'd7, 8'h02);
        step(1, 0, 3'd0, 8'h00);
        checks++; if (key_release !== 1'b1 || gate_active !== 1'b0) $display("FAIL rel_idle rel=%b gate=%b exp 1 0", key_release, gate_active); else passed++;
    endtask

    task automatic test_random();
        bit act, wr;
        logic [2:0] a;
        logic [7:0] d;
        for (int i = 0; i < 1500; i++) begin
            act = ($urandom_range(2) == 0);
            wr  = ($urandom_range(3) == 0);
            a   = 3'($urandom_range(7));
            d   = 8'($urandom);
            if (a == 3'd5) d = 8'($urandom_range(5));
            if (a == 3'd6 && $urandom_range(7) != 0) d = 8'h00;
            step(act, wr, a, d);
            checks++; if (dvec() !== e_out) $display("FAIL random cyc=%0d got=%h exp=%h", i, dvec(), e_out); else passed++;
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_regs();
        test_key_on();
        test_auto_release();
        test_priority();
        test_collision();
        test_back_to_back();
        test_random();
        @(negedge clk);
        active = 1'b0; bus_write = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
